pool_sched: RTL and testbench
=============================

Name: pool_sched

Overview:
Parametrised scheduler/arbiter front-end for the processor pool. It buffers incoming instructions in a FIFO and dispatches each one, as a one-cycle enable pulse, to an idle processor. It arbitrates the processors' shared read and write bus requests independently, in fixed-priority or round-robin mode, holding each grant until the memory side completes the transfer. It also counts processor completions and reports pool idle status to the top-level controller.

Parameters:
PROC_COUNT, 4, number of processors served (>=2)
INSTR_W, 64, instruction word width
FIFO_DEPTH, 4, instruction FIFO entries (power of 2, >=2)
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
CNT_W, 16, completion counter width

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_instr  in  INSTR_W  instruction to enqueue
i_instr_valid  in  1  i_instr valid
o_instr_ready  out  1  FIFO can accept; transfer on valid&ready
o_instr  out  INSTR_W  FIFO head, broadcast to all processors
o_en  out  PROC_COUNT  one-hot dispatch pulse
i_busy  in  PROC_COUNT  processor busy flags
i_finish  in  PROC_COUNT  processor completion pulses
i_req_rd  in  PROC_COUNT  read bus requests
i_req_wr  in  PROC_COUNT  write bus requests
o_grant_rd  out  PROC_COUNT  one-hot read grant
o_grant_wr  out  PROC_COUNT  one-hot write grant
o_rd_sel  out  $clog2(PROC_COUNT)  index of the read grantee (0 when none)
o_wr_sel  out  $clog2(PROC_COUNT)  index of the write grantee (0 when none)
i_mem_rd_done  in  1  read transfer complete (1-cycle pulse)
i_mem_wr_done  in  1  write transfer complete (1-cycle pulse)
o_done_cnt  out  CNT_W  total completions since reset
o_idle  out  1  FIFO empty, no busy, no pending, no grants

Behaviour:
- Reset (i_rst=1 at an edge): FIFO empty; o_instr_ready=1; o_en=0; o_grant_rd=0 and o_grant_wr=0; sel outputs=0; pending mask=0; round-robin pointers=0; o_done_cnt=0; o_idle=1. Reset mid-operation aborts any grant or dispatch immediately; no pulses are emitted in the reset cycle.
- FIFO: o_instr_ready = !full, with no full-bypass. Push and pop in the same cycle are allowed when not full; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH. o_instr shows the head; its value is don't-care when empty.
- Eligibility: processor i is eligible when !i_busy[i] & !pending[i]. pending[i] is set on dispatch and cleared on the first cycle with i_busy[i]=1 or i_finish[i]=1. If set and clear coincide, set wins.
- Dispatch: if the FIFO is non-empty and any processor is eligible, register o_en = one-hot of the selected processor for exactly 1 cycle and pop the FIFO in that cycle. o_instr is valid while o_en is high. At most one dispatch per cycle. An instruction accepted into an empty FIFO at cycle t is dispatched at the earliest at cycle t+1.
- Dispatch selection: ARB_MODE=0 picks the lowest eligible index. ARB_MODE=1 uses round-robin starting at dpt_ptr, and dpt_ptr becomes winner+1 mod PROC_COUNT.
- Read arbiter FSM, IDLE -> GRANT:
  - IDLE: if any i_req_rd bit is set, register a one-hot grant to the winner and set o_rd_sel; go to GRANT. Grant latency is 1 cycle after the request is seen.
  - GRANT: hold the grant until i_mem_rd_done=1 or the grantee drops i_req_rd. Then clear the grant the next cycle and return to IDLE. The round-robin pointer becomes grantee+1.
  - Minimum 1 idle cycle between successive grants. Requests from other processors during GRANT are ignored.
  - i_mem_rd_done while in IDLE is ignored.
- Write arbiter: identical FSM and its own pointer, fully independent of the read arbiter. The same processor may hold a read and a write grant simultaneously.
- Arbitration winner: ARB_MODE=0 picks the lowest requesting index. ARB_MODE=1 picks the first requester at or after the pointer, wrapping.
- o_done_cnt: adds popcount(i_finish) each cycle, registered, wrapping modulo 2^CNT_W. Simultaneous finishes all count.
- o_idle: registered; high when FIFO empty, i_busy=0, pending=0, both arbiters in IDLE, and no push this cycle.

Test Plan:
- Reset then push 3 instructions A,B,C, all processors idle, ARB_MODE=1 -> o_en=0001, 0010, 0100 on consecutive cycles, with o_instr=A,B,C respectively; FIFO empty after the third.
- Push 5 instructions with i_busy=1111, FIFO_DEPTH=4 -> o_instr_ready=0 after 4 accepted and the 5th is held off; release i_busy[2] -> o_en=0100 with the first instruction, and ready returns to 1 the next cycle.
- i_req_rd=1111 held, i_mem_rd_done pulsed 2 cycles after each grant, ARB_MODE=1 -> grant order 0,1,2,3,0 with o_rd_sel=0,1,2,3,0; with ARB_MODE=0 -> grant always to processor 0.
- Processor 1 granted read and write simultaneously; i_mem_wr_done arrives while the read is still open -> only o_grant_wr clears, and o_grant_rd=0010 holds until i_mem_rd_done.
- i_finish=1011 in one cycle, then 0001 -> o_done_cnt=3, then 4; with CNT_W=2, starting at 3 and i_finish=0001 -> wraps to 0.
- Assert i_rst while read granted, FIFO holding 2 instructions, pending=0100 -> next cycle all grants=0, o_en=0, o_instr_ready=1, o_done_cnt=0, o_idle=1.

Source files
------------

// File: rtl/pool_sched.sv
// rtl/pool_sched.sv - instruction dispatch FIFO, read/write bus arbiters and completion counter for the processor pool.
// Dispatch and both bus arbiters share one winner-selection block (fixed priority or round-robin).

module pool_sched_pick #(
   parameter int N  = 4,
   parameter bit RR = 1'b1
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic                 any_o,
   output logic [$clog2(N)-1:0] sel_o
);
   localparam int SEL_W = $clog2(N);

   logic [SEL_W-1:0] idx;

   always_comb begin
      any_o = 1'b0;
      sel_o = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = RR ? SEL_W'((32'(ptr_i) + 32'(k)) % 32'(N)) : SEL_W'(k);
         if (!any_o && req_i[idx]) begin
            any_o = 1'b1;
            sel_o = idx;
         end
      end
   end
endmodule

module pool_sched_arb #(
   parameter int N  = 4,
   parameter bit RR = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req_i,
   input  logic                 done_i,
   output logic [N-1:0]         grant_o,
   output logic [$clog2(N)-1:0] sel_o,
   output logic                 idle_o
);
   localparam int SEL_W = $clog2(N);

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

   arb_state_e       state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             win_any;
   logic [SEL_W-1:0] win_sel;

   pool_sched_pick #(.N(N), .RR(RR)) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .any_o (win_any),
      .sel_o (win_sel)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   // Requests from other processors are not looked at while a grant is open.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (win_any) begin
               grant_d = N'(1) << win_sel;
               sel_d   = win_sel;
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (done_i || !req_i[sel_q]) begin
               grant_d = '0;
               sel_d   = '0;
               ptr_d   = SEL_W'((32'(sel_q) + 32'd1) % 32'(N));
               state_d = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   assign grant_o = grant_q;
   assign sel_o   = sel_q;
   assign idle_o  = (state_q == ARB_IDLE);
endmodule

module pool_sched #(
   parameter int PROC_COUNT = 4,
   parameter int INSTR_W    = 64,
   parameter int FIFO_DEPTH = 4,
   parameter int ARB_MODE   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [INSTR_W-1:0]            i_instr,
   input  logic                          i_instr_valid,
   output logic                          o_instr_ready,
   output logic [INSTR_W-1:0]            o_instr,
   output logic [PROC_COUNT-1:0]         o_en,
   input  logic [PROC_COUNT-1:0]         i_busy,
   input  logic [PROC_COUNT-1:0]         i_finish,
   input  logic [PROC_COUNT-1:0]         i_req_rd,
   input  logic [PROC_COUNT-1:0]         i_req_wr,
   output logic [PROC_COUNT-1:0]         o_grant_rd,
   output logic [PROC_COUNT-1:0]         o_grant_wr,
   output logic [$clog2(PROC_COUNT)-1:0] o_rd_sel,
   output logic [$clog2(PROC_COUNT)-1:0] o_wr_sel,
   input  logic                          i_mem_rd_done,
   input  logic                          i_mem_wr_done,
   output logic [CNT_W-1:0]              o_done_cnt,
   output logic                          o_idle
);
   localparam int SEL_W = $clog2(PROC_COUNT);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam bit RR    = (ARB_MODE != 0);

   logic [INSTR_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [PROC_COUNT-1:0] en_q, en_d;
   logic [PROC_COUNT-1:0] pending_q, pending_d;
   logic [SEL_W-1:0]      dpt_ptr_q, dpt_ptr_d;
   logic [CNT_W-1:0]      done_cnt_q, done_cnt_d;
   logic                  idle_q, idle_d;
   logic [CNT_W-1:0]      fin_sum;
   logic                  push, pop, avail, dispatch, dsp_any, rd_idle, wr_idle;
   logic [SEL_W-1:0]      dsp_sel;

   assign o_instr_ready = (count_q != CW'(FIFO_DEPTH));
   assign push          = i_instr_valid & o_instr_ready;
   assign pop           = |en_q;
   // The head being dispatched this cycle is already spoken for.
   assign avail         = (count_q > {{PTR_W{1'b0}}, pop});
   assign dispatch      = avail & dsp_any;

   pool_sched_pick #(.N(PROC_COUNT), .RR(RR)) u_dsp_pick (
      .req_i (~i_busy & ~pending_q),
      .ptr_i (dpt_ptr_q),
      .any_o (dsp_any),
      .sel_o (dsp_sel)
   );

   pool_sched_arb #(.N(PROC_COUNT), .RR(RR)) u_rd_arb (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .req_i   (i_req_rd),
      .done_i  (i_mem_rd_done),
      .grant_o (o_grant_rd),
      .sel_o   (o_rd_sel),
      .idle_o  (rd_idle)
   );

   pool_sched_arb #(.N(PROC_COUNT), .RR(RR)) u_wr_arb (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .req_i   (i_req_wr),
      .done_i  (i_mem_wr_done),
      .grant_o (o_grant_wr),
      .sel_o   (o_wr_sel),
      .idle_o  (wr_idle)
   );

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_ptr_q] <= i_instr;
   end

   always_comb begin
      fin_sum = '0;
      for (int i = 0; i < PROC_COUNT; i++) fin_sum = fin_sum + CNT_W'(i_finish[i]);
   end

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      en_d       = dispatch ? (PROC_COUNT'(1) << dsp_sel) : '0;
      // A fresh dispatch outranks a same-cycle clear of the same bit.
      pending_d  = (pending_q & ~(i_busy | i_finish)) | en_d;
      dpt_ptr_d  = dispatch ? SEL_W'((32'(dsp_sel) + 32'd1) % 32'(PROC_COUNT)) : dpt_ptr_q;
      done_cnt_d = done_cnt_q + fin_sum;
      idle_d     = (count_q == '0) && (i_busy == '0) && (pending_q == '0)
                   && rd_idle && wr_idle && !push;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         en_q       <= '0;
         pending_q  <= '0;
         dpt_ptr_q  <= '0;
         done_cnt_q <= '0;
         idle_q     <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         en_q       <= en_d;
         pending_q  <= pending_d;
         dpt_ptr_q  <= dpt_ptr_d;
         done_cnt_q <= done_cnt_d;
         idle_q     <= idle_d;
      end
   end

   assign o_instr    = mem_q[rd_ptr_q];
   assign o_en       = en_q;
   assign o_done_cnt = done_cnt_q;
   assign o_idle     = idle_q;
endmodule

// File: tb/tb_pool_sched.sv
// tb/tb_pool_sched.sv - self-checking bench for pool_sched: directed scenarios plus a random run against a queue-based model.
// A second instance uses fixed priority and a 2-bit completion counter.

module tb_pool_sched;
   localparam int N = 4;
   localparam int W = 64;
   localparam int D = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, valid, rd_done, wr_done;
   logic [W-1:0] instr;
   logic [N-1:0] busy, finish, req_rd, req_wr;

   logic         ready, idle;
   logic [W-1:0] instr_o;
   logic [N-1:0] en, grant_rd, grant_wr;
   logic [1:0]   rd_sel, wr_sel;
   logic [15:0]  cnt;

   logic         f_ready, f_idle;
   logic [W-1:0] f_instr;
   logic [N-1:0] f_en, f_grant_rd, f_grant_wr;
   logic [1:0]   f_rd_sel, f_wr_sel, f_cnt;

   int checks = 0;
   int failures = 0;

   pool_sched #(.PROC_COUNT(N), .INSTR_W(W), .FIFO_DEPTH(D), .ARB_MODE(1), .CNT_W(16)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_instr_valid(valid), .o_instr_ready(ready),
      .o_instr(instr_o), .o_en(en), .i_busy(busy), .i_finish(finish), .i_req_rd(req_rd),
      .i_req_wr(req_wr), .o_grant_rd(grant_rd), .o_grant_wr(grant_wr), .o_rd_sel(rd_sel),
      .o_wr_sel(wr_sel), .i_mem_rd_done(rd_done), .i_mem_wr_done(wr_done), .o_done_cnt(cnt),
      .o_idle(idle)
   );

   pool_sched #(.PROC_COUNT(N), .INSTR_W(W), .FIFO_DEPTH(D), .ARB_MODE(0), .CNT_W(2)) u_dut_fp (
      .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_instr_valid(valid), .o_instr_ready(f_ready),
      .o_instr(f_instr), .o_en(f_en), .i_busy(busy), .i_finish(finish), .i_req_rd(req_rd),
      .i_req_wr(req_wr), .o_grant_rd(f_grant_rd), .o_grant_wr(f_grant_wr), .o_rd_sel(f_rd_sel),
      .o_wr_sel(f_wr_sel), .i_mem_rd_done(rd_done), .i_mem_wr_done(wr_done), .o_done_cnt(f_cnt),
      .o_idle(f_idle)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rst = 1'b0; valid = 1'b0; instr = '0; busy = '0; finish = '0;
      req_rd = '0; req_wr = '0; rd_done = 1'b0; wr_done = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic int pick(logic [N-1:0] m, int ptr, bit rr);
      for (int k = 0; k < N; k++) begin
         int idx = rr ? (ptr + k) % N : k;
         if (m[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic test_reset();
      do_reset();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
      checks++; if (en !== 4'b0) begin failures++; $display("FAIL reset_en got=%b exp=0000", en); end
      checks++; if ({grant_rd, grant_wr} !== 8'b0) begin failures++; $display("FAIL reset_grants got=%b exp=0", {grant_rd, grant_wr}); end
      checks++; if ({rd_sel, wr_sel} !== 4'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", {rd_sel, wr_sel}); end
      checks++; if (cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", idle); end
      checks++; if ({f_ready, f_idle, f_cnt} !== 4'b1100) begin failures++; $display("FAIL reset_fp got=%b exp=1100", {f_ready, f_idle, f_cnt}); end
   endtask

   task automatic test_dispatch();
      logic [W-1:0] data [3];
      logic [N-1:0] exp_en [3];
      data[0] = 64'hAAAA_0000_0000_000A; data[1] = 64'hBBBB_0000_0000_000B; data[2] = 64'hCCCC_0000_0000_000C;
      exp_en[0] = 4'b0001; exp_en[1] = 4'b0010; exp_en[2] = 4'b0100;
      do_reset();
      valid = 1'b1; instr = data[0];
      tick();
      for (int k = 0; k < 3; k++) begin
         if (k < 2) instr = data[k+1]; else valid = 1'b0;
         tick();
         checks++; if (en !== exp_en[k]) begin failures++; $display("FAIL dispatch_en%0d got=%b exp=%b", k, en, exp_en[k]); end
         checks++; if (instr_o !== data[k]) begin failures++; $display("FAIL dispatch_instr%0d got=%h exp=%h", k, instr_o, data[k]); end
         checks++; if (f_en !== exp_en[k]) begin failures++; $display("FAIL dispatch_fp_en%0d got=%b exp=%b", k, f_en, exp_en[k]); end
      end
      tick();
      checks++; if (en !== 4'b0) begin failures++; $display("FAIL dispatch_end_en got=%b exp=0000", en); end
      finish = 4'b0111;
      tick();
      finish = '0;
      tick();
      checks++; if (idle !== 1'b1) begin failures++; $display("FAIL dispatch_fifo_empty_idle got=%b exp=1", idle); end
      checks++; if (cnt !== 16'd3) begin failures++; $display("FAIL dispatch_cnt got=%0d exp=3", cnt); end
   endtask

   task automatic test_full();
      logic [W-1:0] data [5];
      for (int k = 0; k < 5; k++) data[k] = {32'hF00D_0000 + 32'(k), $urandom};
      do_reset();
      busy = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         valid = 1'b1; instr = data[k];
         tick();
      end
      instr = data[4];
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_ready_after4 got=%b exp=0", ready); end
      tick();
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_held_off got=%b exp=0", ready); end
      busy = 4'b1011;
      tick();
      checks++; if (en !== 4'b0100) begin failures++; $display("FAIL full_release_en got=%b exp=0100", en); end
      checks++; if (instr_o !== data[0]) begin failures++; $display("FAIL full_release_instr got=%h exp=%h", instr_o, data[0]); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_ready_during_en got=%b exp=0", ready); end
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL full_ready_back got=%b exp=1", ready); end
      checks++; if (en !== 4'b0) begin failures++; $display("FAIL full_no_second_en got=%b exp=0000", en); end
      tick();
      valid = 1'b0;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL full_fifth_accepted got=%b exp=0", ready); end
   endtask

   task automatic test_rd_arb();
      int exp_rr [5];
      exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 2; exp_rr[3] = 3; exp_rr[4] = 0;
      do_reset();
      req_rd = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++; if (grant_rd !== 4'(1 << exp_rr[k]) || rd_sel !== 2'(exp_rr[k])) begin
            failures++; $display("FAIL rd_rr_grant%0d got=%b/%0d exp=%b/%0d", k, grant_rd, rd_sel, 4'(1 << exp_rr[k]), exp_rr[k]); end
         checks++; if (f_grant_rd !== 4'b0001 || f_rd_sel !== 2'd0) begin
            failures++; $display("FAIL rd_fp_grant%0d got=%b/%0d exp=0001/0", k, f_grant_rd, f_rd_sel); end
         tick();
         checks++; if (grant_rd !== 4'(1 << exp_rr[k])) begin failures++; $display("FAIL rd_hold%0d got=%b exp=%b", k, grant_rd, 4'(1 << exp_rr[k])); end
         rd_done = 1'b1;
         tick();
         rd_done = 1'b0;
         checks++; if (grant_rd !== 4'b0 || rd_sel !== 2'd0) begin failures++; $display("FAIL rd_release%0d got=%b/%0d exp=0000/0", k, grant_rd, rd_sel); end
         checks++; if (grant_wr !== 4'b0) begin failures++; $display("FAIL rd_wr_untouched%0d got=%b exp=0000", k, grant_wr); end
         tick();
      end
   endtask

   task automatic test_rd_wr();
      do_reset();
      req_rd = 4'b0010; req_wr = 4'b0010;
      tick();
      checks++; if ({grant_rd, grant_wr} !== 8'b0010_0010) begin failures++; $display("FAIL rdwr_both got=%b exp=00100010", {grant_rd, grant_wr}); end
      checks++; if ({rd_sel, wr_sel} !== 4'b0101) begin failures++; $display("FAIL rdwr_sel got=%b exp=0101", {rd_sel, wr_sel}); end
      wr_done = 1'b1; req_wr = '0;
      tick();
      wr_done = 1'b0;
      checks++; if ({grant_rd, grant_wr} !== 8'b0010_0000) begin failures++; $display("FAIL rdwr_wr_only got=%b exp=00100000", {grant_rd, grant_wr}); end
      tick();
      checks++; if (grant_rd !== 4'b0010) begin failures++; $display("FAIL rdwr_rd_holds got=%b exp=0010", grant_rd); end
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      checks++; if (grant_rd !== 4'b0) begin failures++; $display("FAIL rdwr_rd_release got=%b exp=0000", grant_rd); end
   endtask

   task automatic test_done_cnt();
      do_reset();
      finish = 4'b1011;
      tick();
      checks++; if (cnt !== 16'd3) begin failures++; $display("FAIL cnt_three got=%0d exp=3", cnt); end
      checks++; if (f_cnt !== 2'd3) begin failures++; $display("FAIL cnt_fp_three got=%0d exp=3", f_cnt); end
      finish = 4'b0001;
      tick();
      finish = '0;
      checks++; if (cnt !== 16'd4) begin failures++; $display("FAIL cnt_four got=%0d exp=4", cnt); end
      checks++; if (f_cnt !== 2'd0) begin failures++; $display("FAIL cnt_fp_wrap got=%0d exp=0", f_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      busy = 4'b1011; req_rd = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         valid = 1'b1; instr = {32'hBEEF_0000 + 32'(k), $urandom};
         finish = (k == 0) ? 4'b1000 : 4'b0000;
         tick();
      end
      valid = 1'b0; finish = '0;
      checks++; if (grant_rd !== 4'b0001 || en !== 4'b0) begin failures++; $display("FAIL mid_setup got=%b/%b exp=0001/0000", grant_rd, en); end
      checks++; if (cnt !== 16'd1 || idle !== 1'b0) begin failures++; $display("FAIL mid_setup_cnt got=%0d/%b exp=1/0", cnt, idle); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({grant_rd, grant_wr, f_grant_rd} !== 12'b0) begin failures++; $display("FAIL mid_grants got=%b exp=0", {grant_rd, grant_wr, f_grant_rd}); end
      checks++; if (en !== 4'b0 || f_en !== 4'b0) begin failures++; $display("FAIL mid_en got=%b/%b exp=0000", en, f_en); end
      checks++; if (ready !== 1'b1 || idle !== 1'b1) begin failures++; $display("FAIL mid_ready_idle got=%b/%b exp=1/1", ready, idle); end
      checks++; if (cnt !== 16'd0 || rd_sel !== 2'd0) begin failures++; $display("FAIL mid_cnt_sel got=%0d/%0d exp=0/0", cnt, rd_sel); end
      clear_inputs();
   endtask

   task automatic test_random();
      logic [W-1:0] q [$];
      logic [N-1:0] m_pend, m_en, new_en, elig, exp_g;
      logic [15:0]  m_cnt;
      logic         m_idle, push;
      int m_dptr, m_rg, m_rp, m_wg, m_wp, w;
      do_reset();
      q.delete(); m_pend = '0; m_en = '0; m_dptr = 0; m_rg = -1; m_rp = 0; m_wg = -1; m_wp = 0; m_cnt = '0; m_idle = 1'b1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         checks++; if (en !== m_en) begin failures++; $display("FAIL rnd_en c%0d got=%b exp=%b", cyc, en, m_en); end
         checks++; if (ready !== (q.size() < D)) begin failures++; $display("FAIL rnd_ready c%0d got=%b exp=%b", cyc, ready, q.size() < D); end
         if (m_en != '0) begin
            checks++; if (instr_o !== q[0]) begin failures++; $display("FAIL rnd_instr c%0d got=%h exp=%h", cyc, instr_o, q[0]); end
         end
         exp_g = (m_rg < 0) ? 4'b0 : 4'(1 << m_rg);
         checks++; if (grant_rd !== exp_g || rd_sel !== 2'((m_rg < 0) ? 0 : m_rg)) begin
            failures++; $display("FAIL rnd_rd c%0d got=%b/%0d exp=%b", cyc, grant_rd, rd_sel, exp_g); end
         exp_g = (m_wg < 0) ? 4'b0 : 4'(1 << m_wg);
         checks++; if (grant_wr !== exp_g || wr_sel !== 2'((m_wg < 0) ? 0 : m_wg)) begin
            failures++; $display("FAIL rnd_wr c%0d got=%b/%0d exp=%b", cyc, grant_wr, wr_sel, exp_g); end
         checks++; if (cnt !== m_cnt) begin failures++; $display("FAIL rnd_cnt c%0d got=%0d exp=%0d", cyc, cnt, m_cnt); end
         checks++; if (idle !== m_idle) begin failures++; $display("FAIL rnd_idle c%0d got=%b exp=%b", cyc, idle, m_idle); end

         rst = ($urandom_range(0, 299) == 0);
         valid = $urandom_range(0, 1) == 1;
         instr = {$urandom, $urandom};
         for (int i = 0; i < N; i++) begin
            busy[i]   = ($urandom_range(0, 3) == 0);
            finish[i] = ($urandom_range(0, 6) == 0);
            req_rd[i] = ($urandom_range(0, 4) < 2);
            req_wr[i] = ($urandom_range(0, 4) < 2);
         end
         rd_done = ($urandom_range(0, 9) < 3);
         wr_done = ($urandom_range(0, 9) < 3);

         if (rst) begin
            q.delete(); m_pend = '0; m_en = '0; m_dptr = 0; m_rg = -1; m_rp = 0; m_wg = -1; m_wp = 0; m_cnt = '0; m_idle = 1'b1;
         end else begin
            push   = valid && (q.size() < D);
            elig   = ~busy & ~m_pend;
            w      = (q.size() - ((m_en != '0) ? 1 : 0) > 0) ? pick(elig, m_dptr, 1'b1) : -1;
            new_en = (w >= 0) ? 4'(1 << w) : 4'b0;
            m_idle = (q.size() == 0) && (busy == '0) && (m_pend == '0) && (m_rg < 0) && (m_wg < 0) && !push;
            if (m_en != '0) void'(q.pop_front());
            if (push) q.push_back(instr);
            m_pend = (m_pend & ~(busy | finish)) | new_en;
            if (w >= 0) m_dptr = (w + 1) % N;
            m_en = new_en;
            if (m_rg < 0) m_rg = pick(req_rd, m_rp, 1'b1);
            else if (rd_done || !req_rd[m_rg]) begin m_rp = (m_rg + 1) % N; m_rg = -1; end
            if (m_wg < 0) m_wg = pick(req_wr, m_wp, 1'b1);
            else if (wr_done || !req_wr[m_wg]) begin m_wp = (m_wg + 1) % N; m_wg = -1; end
            m_cnt = m_cnt + 16'($countones(finish));
         end
         tick();
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_dispatch();
      test_full();
      test_rd_arb();
      test_rd_wr();
      test_done_cnt();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
